// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
// Optional hit/miss statistics counters are built in when DCACHE_STAT_EN is defined.
module dcache_ctrl #(
  parameter int LINE_NUM   = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ren,
  input  logic        cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        ram_cs,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_dout,
  input  logic [31:0] ram_din,
`ifdef DCACHE_STAT_EN
  output logic [31:0] stat_hit,
  output logic [31:0] stat_miss,
`endif
  input  logic        ram_ack
);
  localparam int IW = $clog2(LINE_NUM);
  localparam int OW = $clog2(LINE_WORDS);
  localparam int TW = 32 - IW - OW - 2;
  localparam logic [OW-1:0] LAST_WORD = OW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

  state_t              state_q, state_d;
  logic [OW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       req_idx_q, req_idx_d;
  logic [TW-1:0]       req_tag_q, req_tag_d;
  logic [LINE_NUM-1:0] valid_q, valid_d;
  logic [LINE_NUM-1:0] dirty_q, dirty_d;

  logic [TW-1:0] tag_mem  [LINE_NUM];
  logic [31:0]   data_mem [LINE_NUM*LINE_WORDS];

  logic [IW-1:0]    cpu_idx;
  logic [TW-1:0]    cpu_tag;
  logic [OW-1:0]    cpu_off;
  logic             req;
  logic             hit;
  logic             tag_we;
  logic             data_we;
  logic [IW+OW-1:0] data_waddr;
  logic [31:0]      data_wdata;
  logic             unused_addr_bits;

`ifdef DCACHE_STAT_EN
  logic        retry_q, retry_d;
  logic [31:0] stat_hit_q, stat_hit_d;
  logic [31:0] stat_miss_q, stat_miss_d;
  assign stat_hit  = stat_hit_q;
  assign stat_miss = stat_miss_q;
`endif

  assign cpu_off          = cpu_addr[OW+1:2];
  assign cpu_idx          = cpu_addr[IW+OW+1:OW+2];
  assign cpu_tag          = cpu_addr[31:IW+OW+2];
  assign unused_addr_bits = ^cpu_addr[1:0];
  assign req              = cpu_ren | cpu_wen;
  assign hit              = valid_q[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_idx_d  = req_idx_q;
    req_tag_d  = req_tag_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_we     = 1'b0;
    data_we    = 1'b0;
    data_waddr = {cpu_idx, cpu_off};
    data_wdata = cpu_wdata;
    cpu_stall  = 1'b0;
    cpu_rdata  = 32'h0;
    ram_cs     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = 32'h0;
    ram_dout   = 32'h0;
`ifdef DCACHE_STAT_EN
    retry_d     = 1'b0;
    stat_hit_d  = stat_hit_q;
    stat_miss_d = stat_miss_q;
`endif
    case (state_q)
      IDLE: begin
        if (req && hit) begin
          if (cpu_wen) begin
            data_we          = 1'b1;
            dirty_d[cpu_idx] = 1'b1;
          end else begin
            cpu_rdata = data_mem[{cpu_idx, cpu_off}];
          end
`ifdef DCACHE_STAT_EN
          if (!retry_q) stat_hit_d = stat_hit_q + 32'd1;
`endif
        end else if (req) begin
          // The line is invalidated now so an abandoned refill never leaves stale data visible.
          cpu_stall        = 1'b1;
          req_idx_d        = cpu_idx;
          req_tag_d        = cpu_tag;
          cnt_d            = '0;
          valid_d[cpu_idx] = 1'b0;
          state_d          = (valid_q[cpu_idx] && dirty_q[cpu_idx]) ? WB : REFILL;
`ifdef DCACHE_STAT_EN
          stat_miss_d = stat_miss_q + 32'd1;
`endif
        end
      end
      WB: begin
        cpu_stall = 1'b1;
        ram_cs    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = {tag_mem[req_idx_q], req_idx_q, cnt_q, 2'b00};
        ram_dout  = data_mem[{req_idx_q, cnt_q}];
        if (ram_ack) begin
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            state_d = REFILL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      REFILL: begin
        cpu_stall = 1'b1;
        ram_cs    = 1'b1;
        ram_addr  = {req_tag_q, req_idx_q, cnt_q, 2'b00};
        if (ram_ack) begin
          data_we    = 1'b1;
          data_waddr = {req_idx_q, cnt_q};
          data_wdata = ram_din;
          if (cnt_q == LAST_WORD) begin
            tag_we             = 1'b1;
            valid_d[req_idx_q] = 1'b1;
            dirty_d[req_idx_q] = 1'b0;
            cnt_d              = '0;
            state_d            = IDLE;
`ifdef DCACHE_STAT_EN
            retry_d = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_idx_q <= '0;
      req_tag_q <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
`ifdef DCACHE_STAT_EN
      retry_q     <= 1'b0;
      stat_hit_q  <= 32'h0;
      stat_miss_q <= 32'h0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_idx_q <= req_idx_d;
      req_tag_q <= req_tag_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
`ifdef DCACHE_STAT_EN
      retry_q     <= retry_d;
      stat_hit_q  <= stat_hit_d;
      stat_miss_q <= stat_miss_d;
`endif
    end
  end

  // Tag and data arrays carry no reset; validity alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (data_we) data_mem[data_waddr] <= data_wdata;
    if (tag_we) tag_mem[req_idx_q] <= req_tag_q;
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - randomized bench checking dcache_ctrl against a line-level cache and memory model
// Stat counters are also checked when DCACHE_STAT_EN is defined.
module tb_dcache_ctrl;
  localparam int LN = 64;
  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ren, cpu_wen;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ram_cs, ram_we;
  logic [31:0] ram_addr, ram_dout, ram_din;
  logic        ram_ack;
`ifdef DCACHE_STAT_EN
  logic [31:0] stat_hit, stat_miss;
`endif

  always #5 clk = ~clk;

  dcache_ctrl #(.LINE_NUM(LN), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .ram_din(ram_din),
`ifdef DCACHE_STAT_EN
    .stat_hit(stat_hit), .stat_miss(stat_miss),
`endif
    .ram_ack(ram_ack)
  );

  bit          m_valid [LN];
  bit          m_dirty [LN];
  int unsigned m_tag   [LN];
  logic [31:0] m_data  [LN][LW];
  logic [31:0] mem [bit [31:0]];
  int unsigned m_hit, m_miss;
  int          n_vec, n_err;

  typedef struct packed { logic we; logic [31:0] a; logic [31:0] d; } op_t;
  op_t ops[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : a;
  endfunction

  function automatic logic [31:0] la(input int unsigned tag, input int unsigned idx, input int unsigned w);
    return 32'((tag << 10) | (idx << 4) | (w << 2));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < LN; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hit  = 0;
    m_miss = 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; cpu_ren = 1'b0; cpu_wen = 1'b0; ram_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_cpu_stall", cpu_stall, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_ram_cs", ram_cs, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_dout", ram_dout, 0);
`ifdef DCACHE_STAT_EN
    chk("rst_stat_hit", stat_hit, 0);
    chk("rst_stat_miss", stat_miss, 0);
`endif
    rst = 1'b1;
    model_reset();
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = $urandom;
    ram_ack = 1'($urandom_range(0, 1)); ram_din = $urandom;
    #1;
    chk("idle_stall", cpu_stall, 0);
    chk("idle_ram_cs", ram_cs, 0);
  endtask

  // The model decides hit/miss and the whole expected memory transaction before the request starts.
  task automatic run_req(input bit ren, input bit wen, input logic [31:0] addr, input logic [31:0] wd,
                         input int dly, output int stalls, output logic [31:0] rd);
    int unsigned idx, tag, off;
    bit          hit, done;
    int          exp_stall, waits;
    logic [31:0] exp_rd;
    idx = (addr >> 4) % LN;
    tag = addr >> 10;
    off = (addr >> 2) % LW;
    hit = m_valid[idx] && (m_tag[idx] == tag);
    ops.delete();
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx])
        for (int w = 0; w < LW; w++)
          ops.push_back('{we: 1'b1, a: la(m_tag[idx], idx, w), d: m_data[idx][w]});
      for (int w = 0; w < LW; w++) begin
        ops.push_back('{we: 1'b0, a: la(tag, idx, w), d: 32'h0});
        m_data[idx][w] = mem_rd(la(tag, idx, w));
      end
      m_tag[idx] = tag; m_valid[idx] = 1'b1; m_dirty[idx] = 1'b0;
      m_miss++;
    end else begin
      m_hit++;
    end
    exp_stall = hit ? 0 : 1 + ops.size() * (dly + 1);
    exp_rd    = m_data[idx][off];
    if (wen) begin
      m_data[idx][off] = wd;
      m_dirty[idx]     = 1'b1;
    end

    @(negedge clk);
    cpu_ren = ren; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wd; ram_ack = 1'b0;
    stalls = 0; waits = 0; done = 1'b0; rd = 32'h0;
    for (int c = 0; c < 400 && !done; c++) begin
      #1;
      ram_ack = 1'b0;
      if (!cpu_stall) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (ram_cs && ops.size() == 0) begin
          chk("ram_cs_unexpected", ram_cs, 0);
        end else if (ram_cs) begin
          chk("ram_we", ram_we, ops[0].we);
          chk("ram_addr", ram_addr, ops[0].a);
          if (ops[0].we) chk("ram_dout", ram_dout, ops[0].d);
          if (waits == dly) begin
            ram_ack = 1'b1;
            ram_din = ops[0].we ? 32'h0 : mem_rd(ops[0].a);
            if (ops[0].we) mem[ops[0].a] = ops[0].d;
            void'(ops.pop_front());
            waits = 0;
          end else begin
            waits++;
          end
        end
        @(negedge clk);
      end
    end
    if (!done) begin
      chk("req_timeout", 32'd1, 32'd0);
    end else begin
      rd = cpu_rdata;
      chk("stall_cycles", stalls, exp_stall);
      chk("ops_left", ops.size(), 0);
      chk("ram_cs_on_hit", ram_cs, 0);
      if (!wen) chk("cpu_rdata", cpu_rdata, exp_rd);
    end
  endtask

  task automatic reset_mid_refill();
    int n_rd;
    n_rd = 0;
    @(negedge clk);
    cpu_ren = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h0000_5504; ram_ack = 1'b0;
    for (int c = 0; c < 20 && n_rd < 1; c++) begin
      #1;
      ram_ack = 1'b0;
      if (ram_cs && !ram_we) begin
        ram_ack = 1'b1;
        ram_din = mem_rd(ram_addr);
        n_rd++;
      end
      @(negedge clk);
    end
    #1;
    chk("mid_refill_cs", ram_cs, 1);
    chk("mid_refill_addr", ram_addr, 32'h0000_5504);
    rst = 1'b0; ram_ack = 1'b1;
    @(negedge clk);
    #1;
    chk("cs_after_reset", ram_cs, 0);
    rst = 1'b1; ram_ack = 1'b0; cpu_ren = 1'b0;
    model_reset();
  endtask

  initial begin
    int          st;
    logic [31:0] rd;
    int unsigned tags [4];
    int          kind;
    tags = '{0, 1, 4, 9};
    rst = 1'b0; cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    ram_din = 32'h0; ram_ack = 1'b0;
    n_vec = 0; n_err = 0;
    model_reset();
    do_reset();

    run_req(1, 0, 32'h0000_0040, 32'h0, 0, st, rd);
    chk("tp_clean_miss_stall", st, 5);
    chk("tp_clean_miss_rdata", rd, 32'h0000_0040);
    run_req(1, 0, 32'h0000_0040, 32'h0, 0, st, rd);
    run_req(1, 0, 32'h0000_0040, 32'h0, 0, st, rd);
    idle_cycle();
`ifdef DCACHE_STAT_EN
    chk("tp_stat_miss", stat_miss, 1);
    chk("tp_stat_hit", stat_hit, 2);
`endif
    run_req(0, 1, 32'h0000_0044, 32'hDEAD_BEEF, 0, st, rd);
    chk("tp_store_hit_stall", st, 0);
    run_req(1, 0, 32'h0000_0044, 32'h0, 0, st, rd);
    chk("tp_load_hit_stall", st, 0);
    chk("tp_load_hit_rdata", rd, 32'hDEAD_BEEF);
    run_req(1, 0, 32'h0000_1044, 32'h0, 0, st, rd);
    chk("tp_dirty_miss_stall", st, 9);
    chk("tp_dirty_miss_rdata", rd, 32'h0000_1044);
    run_req(1, 0, 32'h0000_2080, 32'h0, 3, st, rd);
    chk("tp_slow_ack_stall", st, 17);
    chk("tp_slow_ack_rdata", rd, 32'h0000_2080);
    reset_mid_refill();
    run_req(1, 0, 32'h0000_5504, 32'h0, 0, st, rd);
    chk("tp_after_reset_stall", st, 5);
    chk("tp_after_reset_rdata", rd, 32'h0000_5504);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle_cycle();
      end else begin
        kind = $urandom_range(0, 2);
        run_req(kind != 1, kind != 0,
                la(tags[$urandom_range(0, 3)], $urandom_range(0, 3), $urandom_range(0, 3)),
                $urandom, $urandom_range(0, 2), st, rd);
      end
    end
    idle_cycle();
`ifdef DCACHE_STAT_EN
    chk("stat_miss_total", stat_miss, m_miss);
    chk("stat_hit_total", stat_hit, m_hit);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

- Direct-mapped, write-back, write-allocate data cache between the pipeline core's data-memory port and the main-memory bus.
- Core side: hits are answered in the same cycle; misses are reported through a stall signal.
- Memory side: misses are serviced with a word-serial request/acknowledge handshake (dirty-line writeback, then line refill).
- The block supplies the core's read data and data-stall signal.

## Interface

Parameters:
- `LINE_NUM`, 64: number of cache lines (power of two). Index width `IW` = log2(LINE_NUM).
- `LINE_WORDS`, 4: 32-bit words per line (power of two). Offset width `OW` = log2(LINE_WORDS).

Ports (clock and reset first):
- `clk` in 1: main clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `cpu_ren` in 1: core load request.
- `cpu_wen` in 1: core store request.
- `cpu_addr` in 32: byte address. Bits [1:0] are ignored.
- `cpu_wdata` in 32: store data.
- `cpu_rdata` out 32: load data.
- `cpu_stall` out 1: request not yet complete. The core holds the request stable while this is high.
- `ram_cs` out 1: memory word request.
- `ram_we` out 1: 1 = write word, 0 = read word.
- `ram_addr` out 32: word-aligned memory address.
- `ram_dout` out 32: writeback data.
- `ram_din` in 32: refill data, valid when `ram_ack` is high.
- `ram_ack` in 1: current word transfer complete this cycle.

## Operation

Address split:
- Word offset = addr[OW+1:2].
- Index = addr[IW+OW+1:OW+2].
- Tag = addr[31:IW+OW+2].

Per-line state: valid bit, dirty bit, tag, LINE_WORDS data words.

Request rules:
- No request (ren=0, wen=0): `cpu_stall`=0.
- ren=1 and wen=1 together: treated as a store.

FSM states: IDLE, WB, REFILL.
- IDLE, hit (valid and tag match):
  - `cpu_stall`=0.
  - Load: `cpu_rdata` = addressed word, combinationally.
  - Store: word written and dirty set at the clock edge.
- IDLE, miss: `cpu_stall`=1 that cycle. Next state is WB if the victim is valid and dirty, else REFILL. Word counter cleared.
- WB:
  - Drives `ram_cs`=1, `ram_we`=1.
  - `ram_addr` = {victim tag, index, counter, 2'b00}; `ram_dout` = victim word[counter].
  - On `ram_ack`, counter increments.
  - On ack of the last word: counter cleared, go to REFILL.
- REFILL:
  - Drives `ram_cs`=1, `ram_we`=0.
  - `ram_addr` = {request tag, index, counter, 2'b00}.
  - On `ram_ack`, `ram_din` is written to word[counter] and counter increments.
  - On ack of the last word: tag written, valid=1, dirty=0, go to IDLE. The request then hits and completes.
- `cpu_stall`=1 in WB and REFILL.
- `ram_cs`, `ram_we`, `ram_addr` and `ram_dout` are combinational decodes of state and counter. `ram_cs` stays high across consecutive words.
- While a miss is serviced, the cache ignores any change on the core inputs except the address tag/index already captured into the request registers at miss detection.

## Timing

Reset values (`rst`=0 at an edge):
- State IDLE, counter 0, all valid and dirty bits 0.
- `ram_cs`=0, `ram_we`=0, `ram_addr`=0, `ram_dout`=0.
- `cpu_stall`=0 with no request; `cpu_rdata`=0.
- Data and tag arrays are not cleared.

Latency:
- Hit: 0 cycles.
- Clean miss with single-cycle ack: `cpu_stall` high for 1 + LINE_WORDS cycles (5 at the default). Data valid in the cycle `cpu_stall` falls.
- Dirty miss: adds LINE_WORDS cycles per the same rule.
- Each additional wait cycle before `ram_ack` adds one cycle.

Boundary conditions:
- Reset mid-WB or mid-REFILL: transfer abandoned; `ram_cs`=0 in the cycle after the reset edge. The partially filled line stays invalid.
- Counter wraps from LINE_WORDS-1 to 0 only by the state transition.
- `ram_ack` outside WB/REFILL is ignored.
- Store miss: after refill, the store hits in IDLE and sets dirty.

## Configuration

Macro `DCACHE_STAT_EN`.

Defined:
- Adds outputs `stat_hit` (32) and `stat_miss` (32), both reset to 0, wrapping at 2^32.
- `stat_miss` increments once per miss detection in IDLE.
- `stat_hit` increments on a hit in IDLE, except the completing hit immediately after a REFILL.
- That exception is tracked by a one-cycle `retry` flag, set on refill completion.

Undefined:
- Ports, counters and the flag are absent; behaviour is otherwise identical.

## Test plan

- Reset, then load 0x0000_0040 with a memory model holding word = address and single-cycle ack:
  - `cpu_stall` high 5 cycles; 4 reads at 0x40, 0x44, 0x48, 0x4C.
  - Then `cpu_rdata`=0x0000_0040, stall 0.
- Store 0xDEAD_BEEF to 0x44 (hit), then load 0x44: both 0-cycle; `cpu_rdata`=0xDEAD_BEEF, no `ram_cs`.
- Load 0x0000_1044 (same index, different tag) after the above:
  - 4 writes starting 0x40 with 0xDEAD_BEEF at 0x44.
  - Then 4 reads from 0x1040; stall 9 cycles.
- Memory ack delayed 3 cycles per word on a clean miss: stall lasts 1 + 4×4 = 17 cycles; `ram_addr` held stable during each wait.
- Assert `rst`=0 during the second refill word:
  - `ram_cs`=0 next cycle.
  - A following load to the same address misses again.
- With `DCACHE_STAT_EN`: miss, hit, hit on 0x40 gives `stat_miss`=1, `stat_hit`=2.
